game_sequencer: RTL and testbench
=================================

# game_sequencer

Parametrised top-level game controller. It combines an outer game FSM (wait / play / pause / hit / end) with an inner per-pixel read-modify-write sequencer. The inner sequencer walks an H_RES×V_RES frame and generates the pixel coordinates itself. The block sits between the key/collision/frame-tick sources and the frame-buffer datapath, which decodes `play_state` to drive its read and write strobes. New behaviour: pause mode, lives with respawn delay, frame-complete wait, overrun detection, and edge-detected keys.

## Interface
Parameters:
- H_RES, 160, pixels per line; ≥2
- V_RES, 120, lines per frame; ≥2
- LIVES, 3, lives loaded at game start; ≥1
- HIT_CYCLES, 60, clocks spent in HIT before resuming PLAY; ≥1

Widths: XW=$clog2(H_RES), YW=$clog2(V_RES), LW=$clog2(LIVES+1).

Ports:
- clock  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous, active-low reset
- key_start  in  1  start key level, synchronous to clock
- key_pause  in  1  pause key level, synchronous to clock
- sig_collision  in  1  collision level from datapath
- sig_next_frame  in  1  one-cycle frame tick
- core_state  out  3  outer FSM state
- play_state  out  3  inner FSM state
- pixel_x  out  XW  current pixel column
- pixel_y  out  YW  current pixel row
- lives  out  LW  remaining lives
- frame_overrun  out  1  sticky: frame tick arrived before the walk finished

## Operation
- Key presses: a press is key high now and low on the previous cycle. The previous-value registers reset to 1, so a key held through reset does not register as a press.
- Outer FSM codes: WAIT=0, PLAY=1, PAUSE=2, HIT=3, END=4. Codes 5–7 go to WAIT.
- WAIT: on start press, go to PLAY, load lives←LIVES, and clear frame_overrun.
- PLAY: on sig_collision, if lives==1 go to END with lives←0; otherwise go to HIT with lives−1. If there is no collision, a pause press goes to PAUSE. Collision takes priority over pause.
- PAUSE: a pause press returns to PLAY. Start presses and collisions are ignored.
- HIT: a counter runs 0..HIT_CYCLES−1 and then the FSM returns to PLAY. Collisions are ignored in HIT.
- END: a start press goes to WAIT. lives holds at 0.
- Inner FSM codes: INIT=0, READ_NEXT=1, READ=2, WRITE=3, NEXT_PIXEL=4, FRAME_WAIT=5. Codes 6–7 go to INIT.
- Inner FSM behaviour depends on the current outer state:
  - PLAY: the inner FSM advances.
  - PAUSE: the inner state and pixel_x/pixel_y hold.
  - WAIT, HIT, END: the inner FSM is forced to INIT with x=y=0.
- Inner transitions:
  - INIT: x←0, y←0, then go to READ_NEXT.
  - READ_NEXT → READ → WRITE → NEXT_PIXEL.
  - NEXT_PIXEL, at the last pixel (x=H_RES−1, y=V_RES−1): go to FRAME_WAIT.
  - NEXT_PIXEL, otherwise: x+1, or at x=H_RES−1 wrap x←0 and y+1; then go to READ_NEXT.
  - FRAME_WAIT: on sig_next_frame, go to INIT.
- Overrun: if sig_next_frame arrives in PLAY while the inner state is READ_NEXT, READ, WRITE or NEXT_PIXEL:
  - the inner FSM aborts to INIT;
  - frame_overrun is set and stays set until the next WAIT→PLAY transition.
- sig_next_frame in INIT has no effect.

## Timing
- Reset: all outputs reset to 0, with core_state=WAIT and play_state=INIT. The HIT counter and key-previous registers also reset. Reset wins over any simultaneous event.
- Every output is a register, updated on the posedge after its cause.
- Key press to core_state=PLAY takes 1 cycle. Collision to HIT or END takes 1 cycle.
- Pixel cadence:
  - INIT lasts 1 cycle, then each pixel takes 4 cycles.
  - FRAME_WAIT is reached 1+4·H_RES·V_RES cycles after play_state first shows INIT.
- pixel_x/pixel_y are stable from READ_NEXT through NEXT_PIXEL and change at the NEXT_PIXEL→READ_NEXT edge.
- A collision in the same cycle as sig_next_frame: the outer FSM leaves PLAY. The inner FSM evaluates that edge under PLAY rules and is then forced to INIT on the following edge.
- HIT lasts exactly HIT_CYCLES cycles.

## Structure
- Package game_pkg holds:
  - outer-state and inner-state localparams;
  - width helper functions for XW, YW and LW.
- Sub-module key_edge is the rising-edge detector with a reset-to-1 previous register. It is instantiated twice, once for start and once for pause.
- The outer FSM, inner FSM, pixel counters, lives counter, HIT counter and overrun flag live in game_sequencer. Target size is about 200 lines.

## Test plan
Benches use H_RES=4, V_RES=2, LIVES=2, HIT_CYCLES=3.
- Start after reset:
  - Hold key_start high through reset, then release → stays in WAIT.
  - Pulse key_start → core_state=1 next cycle, lives=2.
- Full frame walk: in PLAY with no ticks → (x,y) goes (0,0)…(3,0),(0,1)…(3,1). play_state=5 at 33 cycles after INIT. A tick then gives INIT, and frame_overrun stays 0.
- Overrun: tick during pixel (2,0) → INIT next cycle, frame_overrun=1. The flag holds through frames until a new game starts.
- Pause:
  - Pause press at READ of (1,1) → core_state=2. play_state=2 and x=1,y=1 hold for 10 cycles, and a collision is ignored.
  - A second pause press resumes PLAY, and the walk continues at WRITE.
- Lives and end:
  - First collision → HIT, lives=1, 3 cycles in HIT, back to PLAY at INIT.
  - Second collision → END, lives=0.
  - Start press → WAIT.
- Priority: collision and pause press in the same cycle → HIT, not PAUSE.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings and width helpers for game_sequencer
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        CORE_WAIT  = 3'd0,
        CORE_PLAY  = 3'd1,
        CORE_PAUSE = 3'd2,
        CORE_HIT   = 3'd3,
        CORE_END   = 3'd4
    } core_state_t;

    typedef enum logic [STATE_W-1:0] {
        PLAY_INIT       = 3'd0,
        PLAY_READ_NEXT  = 3'd1,
        PLAY_READ       = 3'd2,
        PLAY_WRITE      = 3'd3,
        PLAY_NEXT_PIXEL = 3'd4,
        PLAY_FRAME_WAIT = 3'd5
    } play_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int xw_of(input int h_res);
        return cnt_width(h_res);
    endfunction

    function automatic int yw_of(input int v_res);
        return cnt_width(v_res);
    endfunction

    // Lives must be able to hold LIVES itself, hence the +1.
    function automatic int lw_of(input int lives);
        return cnt_width(lives + 1);
    endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - rising-edge detector for a synchronous key level
module key_edge (
    input  logic clock,
    input  logic resetn,
    input  logic key,
    output logic press
);

    logic key_prev;

    // Previous level resets high so a key held through reset is not a press.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            key_prev <= 1'b1;
        end else begin
            key_prev <= key;
        end
    end

    assign press = key & ~key_prev;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - outer game FSM plus per-pixel read-modify-write sequencer
module game_sequencer
    import game_pkg::*;
#(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int LIVES      = 3,
    parameter int HIT_CYCLES = 60,
    localparam int XW        = xw_of(H_RES),
    localparam int YW        = yw_of(V_RES),
    localparam int LW        = lw_of(LIVES)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          key_start,
    input  logic          key_pause,
    input  logic          sig_collision,
    input  logic          sig_next_frame,
    output logic [2:0]    core_state,
    output logic [2:0]    play_state,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic [LW-1:0] lives,
    output logic          frame_overrun
);

    localparam int HW = cnt_width(HIT_CYCLES);

    logic start_press;
    logic pause_press;

    core_state_t   core_q, core_d;
    play_state_t   play_q, play_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [HW-1:0] hit_q, hit_d;
    logic          overrun_q, overrun_d;

    logic          walking;
    logic          last_x;
    logic          last_pixel;

    key_edge u_start_edge (
        .clock  (clock),
        .resetn (resetn),
        .key    (key_start),
        .press  (start_press)
    );

    key_edge u_pause_edge (
        .clock  (clock),
        .resetn (resetn),
        .key    (key_pause),
        .press  (pause_press)
    );

    // A frame tick while a pixel is in flight means the walk overran the frame.
    assign walking    = (play_q == PLAY_READ_NEXT) || (play_q == PLAY_READ) ||
                        (play_q == PLAY_WRITE)     || (play_q == PLAY_NEXT_PIXEL);
    assign last_x     = (x_q == XW'(H_RES - 1));
    assign last_pixel = last_x && (y_q == YW'(V_RES - 1));

    // State register for both FSMs and all counters.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            core_q    <= CORE_WAIT;
            play_q    <= PLAY_INIT;
            x_q       <= '0;
            y_q       <= '0;
            lives_q   <= '0;
            hit_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            core_q    <= core_d;
            play_q    <= play_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
            overrun_q <= overrun_d;
        end
    end

    // Outer game FSM: lives, HIT dwell counter and sticky overrun flag.
    always_comb begin
        core_d    = core_q;
        lives_d   = lives_q;
        hit_d     = '0;
        overrun_d = overrun_q;
        case (core_q)
            CORE_WAIT: begin
                if (start_press) begin
                    core_d    = CORE_PLAY;
                    lives_d   = LW'(LIVES);
                    overrun_d = 1'b0;
                end
            end
            CORE_PLAY: begin
                if (sig_next_frame && walking) begin
                    overrun_d = 1'b1;
                end
                // Collision outranks a pause press in the same cycle.
                if (sig_collision) begin
                    if (lives_q == LW'(1)) begin
                        core_d  = CORE_END;
                        lives_d = '0;
                    end else begin
                        core_d  = CORE_HIT;
                        lives_d = lives_q - LW'(1);
                    end
                end else if (pause_press) begin
                    core_d = CORE_PAUSE;
                end
            end
            CORE_PAUSE: begin
                if (pause_press) begin
                    core_d = CORE_PLAY;
                end
            end
            CORE_HIT: begin
                if (hit_q == HW'(HIT_CYCLES - 1)) begin
                    core_d = CORE_PLAY;
                end else begin
                    hit_d = hit_q + HW'(1);
                end
            end
            CORE_END: begin
                lives_d = '0;
                if (start_press) begin
                    core_d = CORE_WAIT;
                end
            end
            default: begin
                core_d = CORE_WAIT;
            end
        endcase
    end

    // Inner pixel sequencer: advances in PLAY, freezes in PAUSE, parked otherwise.
    always_comb begin
        play_d = play_q;
        x_d    = x_q;
        y_d    = y_q;
        case (core_q)
            CORE_PLAY: begin
                case (play_q)
                    PLAY_INIT: begin
                        play_d = PLAY_READ_NEXT;
                        x_d    = '0;
                        y_d    = '0;
                    end
                    PLAY_READ_NEXT, PLAY_READ, PLAY_WRITE, PLAY_NEXT_PIXEL: begin
                        if (sig_next_frame) begin
                            play_d = PLAY_INIT;
                            x_d    = '0;
                            y_d    = '0;
                        end else if (play_q == PLAY_READ_NEXT) begin
                            play_d = PLAY_READ;
                        end else if (play_q == PLAY_READ) begin
                            play_d = PLAY_WRITE;
                        end else if (play_q == PLAY_WRITE) begin
                            play_d = PLAY_NEXT_PIXEL;
                        end else if (last_pixel) begin
                            play_d = PLAY_FRAME_WAIT;
                        end else begin
                            play_d = PLAY_READ_NEXT;
                            if (last_x) begin
                                x_d = '0;
                                y_d = y_q + YW'(1);
                            end else begin
                                x_d = x_q + XW'(1);
                            end
                        end
                    end
                    PLAY_FRAME_WAIT: begin
                        if (sig_next_frame) begin
                            play_d = PLAY_INIT;
                            x_d    = '0;
                            y_d    = '0;
                        end
                    end
                    default: begin
                        play_d = PLAY_INIT;
                        x_d    = '0;
                        y_d    = '0;
                    end
                endcase
            end
            CORE_PAUSE: begin
                play_d = play_q;
            end
            default: begin
                play_d = PLAY_INIT;
                x_d    = '0;
                y_d    = '0;
            end
        endcase
    end

    assign core_state    = core_q;
    assign play_state    = play_q;
    assign pixel_x       = x_q;
    assign pixel_y       = y_q;
    assign lives         = lives_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

    localparam int H_RES      = 4;
    localparam int V_RES      = 2;
    localparam int LIVES      = 2;
    localparam int HIT_CYCLES = 3;

    logic       clock;
    logic       resetn;
    logic       key_start;
    logic       key_pause;
    logic       sig_collision;
    logic       sig_next_frame;
    logic [2:0] core_state;
    logic [2:0] play_state;
    logic [1:0] pixel_x;
    logic [0:0] pixel_y;
    logic [1:0] lives;
    logic       frame_overrun;

    int total = 0;
    int bad   = 0;

    game_sequencer #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .LIVES      (LIVES),
        .HIT_CYCLES (HIT_CYCLES)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .key_start      (key_start),
        .key_pause      (key_pause),
        .sig_collision  (sig_collision),
        .sig_next_frame (sig_next_frame),
        .core_state     (core_state),
        .play_state     (play_state),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .lives          (lives),
        .frame_overrun  (frame_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn         = 1'b0;
        key_start      = 1'b1;
        key_pause      = 1'b0;
        sig_collision  = 1'b0;
        sig_next_frame = 1'b0;
        cyc(3);
        chk("rst_core", core_state, 0);
        chk("rst_play", play_state, 0);
        chk("rst_x", pixel_x, 0);
        chk("rst_y", pixel_y, 0);
        chk("rst_lives", lives, 0);
        chk("rst_overrun", frame_overrun, 0);

        // start held through reset is not a press
        resetn = 1'b1;
        cyc(1);
        key_start = 1'b0;
        cyc(2);
        chk("held_start_wait", core_state, 0);

        // start press
        key_start = 1'b1;
        cyc(1);
        key_start = 1'b0;
        chk("start_core", core_state, 1);
        chk("start_lives", lives, 2);
        chk("start_play_init", play_state, 0);

        // full frame walk, 4 cycles per pixel
        for (int p = 0; p < 8; p++) begin
            for (int s = 1; s <= 4; s++) begin
                cyc(1);
                chk("walk_play", play_state, s);
                chk("walk_x", pixel_x, p % 4);
                chk("walk_y", pixel_y, p / 4);
            end
        end
        cyc(1);
        chk("frame_wait_33", play_state, 5);
        cyc(2);
        chk("frame_wait_hold", play_state, 5);
        sig_next_frame = 1'b1;
        cyc(1);
        sig_next_frame = 1'b0;
        chk("tick_init", play_state, 0);
        chk("tick_no_overrun", frame_overrun, 0);

        // overrun during pixel (2,0)
        cyc(9);
        chk("ovr_rn_play", play_state, 1);
        chk("ovr_rn_x", pixel_x, 2);
        chk("ovr_rn_y", pixel_y, 0);
        cyc(1);
        chk("ovr_read", play_state, 2);
        sig_next_frame = 1'b1;
        cyc(1);
        sig_next_frame = 1'b0;
        chk("ovr_abort_init", play_state, 0);
        chk("ovr_flag", frame_overrun, 1);
        cyc(33);
        chk("ovr_frame2_wait", play_state, 5);
        chk("ovr_flag_hold", frame_overrun, 1);
        sig_next_frame = 1'b1;
        cyc(1);
        sig_next_frame = 1'b0;
        chk("ovr_init2", play_state, 0);
        chk("ovr_flag_hold2", frame_overrun, 1);

        // pause at READ of (1,1): press during READ_NEXT
        cyc(21);
        chk("pause_rn", play_state, 1);
        chk("pause_rn_x", pixel_x, 1);
        chk("pause_rn_y", pixel_y, 1);
        key_pause = 1'b1;
        cyc(1);
        key_pause = 1'b0;
        chk("pause_core", core_state, 2);
        chk("pause_play", play_state, 2);
        sig_collision = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("pause_hold_core", core_state, 2);
            chk("pause_hold_play", play_state, 2);
            chk("pause_hold_x", pixel_x, 1);
            chk("pause_hold_y", pixel_y, 1);
        end
        sig_collision = 1'b0;
        chk("pause_lives", lives, 2);
        key_pause = 1'b1;
        cyc(1);
        key_pause = 1'b0;
        chk("resume_core", core_state, 1);
        chk("resume_play", play_state, 2);
        cyc(1);
        chk("resume_write", play_state, 3);

        // first collision: HIT for 3 cycles
        sig_collision = 1'b1;
        cyc(1);
        sig_collision = 1'b0;
        chk("hit_core", core_state, 3);
        chk("hit_lives", lives, 1);
        cyc(1);
        chk("hit_core2", core_state, 3);
        chk("hit_play_init", play_state, 0);
        cyc(1);
        chk("hit_core3", core_state, 3);
        cyc(1);
        chk("hit_back_play", core_state, 1);
        chk("hit_back_init", play_state, 0);
        cyc(1);
        chk("hit_walk_rn", play_state, 1);
        chk("hit_walk_x", pixel_x, 0);

        // second collision: END
        sig_collision = 1'b1;
        cyc(1);
        sig_collision = 1'b0;
        chk("end_core", core_state, 4);
        chk("end_lives", lives, 0);
        cyc(1);
        chk("end_play_init", play_state, 0);
        key_start = 1'b1;
        cyc(1);
        key_start = 1'b0;
        chk("end_to_wait", core_state, 0);
        cyc(1);
        chk("wait_overrun_kept", frame_overrun, 1);

        // new game clears overrun
        key_start = 1'b1;
        cyc(1);
        key_start = 1'b0;
        chk("game2_core", core_state, 1);
        chk("game2_lives", lives, 2);
        chk("game2_overrun", frame_overrun, 0);
        cyc(1);
        chk("game2_rn", play_state, 1);

        // collision beats pause press
        sig_collision = 1'b1;
        key_pause     = 1'b1;
        cyc(1);
        sig_collision = 1'b0;
        key_pause     = 1'b0;
        chk("prio_core", core_state, 3);
        chk("prio_lives", lives, 1);

        // reset wins over a simultaneous start press
        cyc(5);
        chk("prio_after_hit", core_state, 1);
        resetn    = 1'b0;
        key_start = 1'b1;
        cyc(1);
        chk("rst_win_core", core_state, 0);
        chk("rst_win_lives", lives, 0);
        chk("rst_win_play", play_state, 0);
        resetn    = 1'b1;
        key_start = 1'b0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
